vend_req_scheduler: RTL and testbench
=====================================

Name: vend_req_scheduler

Overview:
- Front-end controller for the vending FSM. Converts raw level buttons (nickel, dime, quarter, soda, diet) into single-cycle request pulses and issues at most one request per slot, spaced so the FSM sees each one cleanly.
- Arbitrates simultaneous presses with fixed priority and holds off issuing while the FSM is dispensing or returning change.
- Tracks soda/diet inventory and rejects selections of sold-out products.

Parameters:
- INV_W, 4, inventory counter width.
- INV_INIT, 10, per-product stock loaded at reset and on restock; must fit in INV_W bits.
- GAP_CYCLES, 2, idle cycles forced after every issued pulse; must be ≥1.
- DB_CYCLES, 3, stable-sample count for the debouncer (used only with DEBOUNCE_EN).

Ports:
- CLK  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- btn_ni, btn_di, btn_qu  in  1 each  raw coin inputs, level, already synchronised.
- btn_soda, btn_diet  in  1 each  raw selection inputs, level.
- restock  in  1  level; reloads both inventories to INV_INIT.
- giveSoda, giveDiet, change  in  1 each  feedback from the vending FSM.
- ni, di, qu, soda, diet  out  1 each  one-cycle request pulses to the FSM; at most one high per cycle.
- reject  out  1  one-cycle pulse when a selection is dropped because that product is sold out.
- soda_out, diet_out  out  1 each  level; that inventory is 0.
- soda_cnt, diet_cnt  out  INV_W each  current inventory.

Behaviour:
- Reset: all pulse outputs and reject = 0; pending bits cleared; inventories = INV_INIT; sold-out flags = 0; state = IDLE; gap counter = 0.
- Edge detect: a 0→1 transition on any btn_* sets its pending bit one cycle after the edge. Holding a button produces no further requests. A new edge while that bit is already pending is absorbed, so at most one request per source is outstanding.
- State IDLE:
  - If change=1, go to HOLD.
  - Otherwise, if any coin is pending, issue the highest-priority one (qu > di > ni), clear its bit and go to GAP.
  - Otherwise, if a selection is pending (soda > diet):
    - If that product's count > 0, issue its pulse, clear the bit and go to GAP.
    - If its count = 0, clear the bit, pulse reject and stay in IDLE.
- Issue latency: the pulse appears in the cycle the scheduler is in IDLE with the bit pending. Minimum latency from button edge to pulse is 2 cycles.
- State GAP: hold for GAP_CYCLES cycles with all pulses low, then go to IDLE (or to HOLD if change=1 at exit).
- State HOLD: no issuing. Return to IDLE once change=0 and giveSoda=0 and giveDiet=0. Pending bits keep accumulating during HOLD.
- Inventory:
  - On a 0→1 edge of giveSoda, decrement soda_cnt by 1; on a 0→1 edge of giveDiet, decrement diet_cnt by 1.
  - Counters saturate at 0 and never wrap.
  - soda_out/diet_out equal (count == 0), updated in the same cycle the count changes.
- restock: on any cycle with restock=1, reload both counts to INV_INIT. This overrides a same-cycle decrement. Does not affect pending bits or state.
- Simultaneous edges on several buttons: all of them are latched, then issued one per slot in priority order.
- A reset asserted mid-GAP or mid-HOLD returns to the reset state on the next edge; pending requests are lost.

Optional Feature:
- DEBOUNCE_EN defined: each btn_* passes through a debouncer. The debounced level changes only after DB_CYCLES consecutive equal samples, adding DB_CYCLES cycles of latency. A glitch shorter than DB_CYCLES produces no request.
- DEBOUNCE_EN undefined: inputs feed the edge detectors directly; DB_CYCLES is ignored.

Decomposition:
- Shared package vend_pkg:
  - scheduler state encoding (IDLE, GAP, HOLD);
  - request index constants (REQ_QU, REQ_DI, REQ_NI, REQ_SODA, REQ_DIET) and the priority order;
  - INV_INIT default.
- One sub-module, vend_btn_cond (per-input debounce + rising-edge detect), instantiated five times; its debounce logic is gated by DEBOUNCE_EN.

Test Plan:
- btn_qu rises at cycle 10 and is held 20 cycles → exactly one qu pulse, at cycle 12; no others.
- btn_ni, btn_di and btn_qu rise in the same cycle, GAP_CYCLES=2 → pulse order qu, di, ni, spaced 3 cycles apart.
- change=1 for 5 cycles while di is pending → no pulse during that window; di issues in the first IDLE cycle after change=0.
- Ten giveSoda rising edges from reset → soda_cnt=0 and soda_out=1. The next btn_soda edge gives reject=1 for one cycle and no soda pulse; btn_diet still issues diet.
- restock and a giveDiet edge in the same cycle with diet_cnt=3 → diet_cnt=10.
- With DEBOUNCE_EN defined, a 2-cycle btn_ni glitch → no pulse. A 5-cycle press → one ni pulse, DB_CYCLES cycles later than the undebounced build.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending request scheduler: scheduler states,
// request indices with their issue priority, and the default stock level.
package vend_pkg;

   // Scheduler states: IDLE may issue, GAP spaces pulses, HOLD waits on the FSM
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GAP  = 2'd1,
      ST_HOLD = 2'd2
   } sched_state_t;

   localparam int NUM_REQ = 5;

   // Bit positions of each request source in the pending/issue vectors
   localparam logic [2:0] REQ_NI   = 3'd0;
   localparam logic [2:0] REQ_DI   = 3'd1;
   localparam logic [2:0] REQ_QU   = 3'd2;
   localparam logic [2:0] REQ_SODA = 3'd3;
   localparam logic [2:0] REQ_DIET = 3'd4;

   // Highest priority first: coins (qu > di > ni) always beat selections (soda > diet)
   localparam logic [2:0] PRIO_ORDER [NUM_REQ] = '{REQ_QU, REQ_DI, REQ_NI, REQ_SODA, REQ_DIET};

   localparam int INV_INIT_DEF = 10;

endpackage

// File: rtl/vend_btn_cond.sv
// Per-button conditioner: input sample register, optional debounce filter
// (enabled by the DEBOUNCE_EN macro), and a rising-edge detector whose
// output is high for one cycle per accepted press.
module vend_btn_cond #(
   parameter int DB_CYCLES = 3
) (
   input  logic CLK,
   input  logic rst,
   input  logic i_btn,
   output logic o_rise
);

   // Debounce length; zero bypasses the filter entirely
`ifdef DEBOUNCE_EN
   localparam int DB_LEN = DB_CYCLES;
`else
   localparam int DB_LEN = DB_CYCLES * 0;
`endif

   logic r_sync;
   logic r_prev;
   logic w_level;

   // Register the raw level so an edge is seen one cycle after it occurs
   always_ff @(posedge CLK) begin
      if (rst) r_sync <= 1'b0;
      else     r_sync <= i_btn;
   end

   generate
      if (DB_LEN > 0) begin : g_debounce
         localparam int CNT_W = $clog2(DB_LEN + 1);
         logic [CNT_W-1:0] r_db_cnt;
         logic             r_db_level;

         // Accept a new level only after DB_LEN consecutive differing samples
         always_ff @(posedge CLK) begin
            if (rst) begin
               r_db_cnt   <= '0;
               r_db_level <= 1'b0;
            end else if (r_sync == r_db_level) begin
               r_db_cnt <= '0;
            end else if (r_db_cnt == CNT_W'(DB_LEN - 1)) begin
               r_db_level <= r_sync;
               r_db_cnt   <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + 1'b1;
            end
         end

         assign w_level = r_db_level;
      end else begin : g_direct
         assign w_level = r_sync;
      end
   endgenerate

   // Previous conditioned level for edge detection
   always_ff @(posedge CLK) begin
      if (rst) r_prev <= 1'b0;
      else     r_prev <= w_level;
   end

   assign o_rise = w_level & ~r_prev;

endmodule

// File: rtl/vend_req_scheduler.sv
// Front-end request scheduler for the vending FSM. Turns button presses into
// spaced single-cycle request pulses, arbitrates by fixed priority, holds off
// while the FSM is busy, and tracks soda/diet stock. Button debouncing is
// included when DEBOUNCE_EN is defined.
module vend_req_scheduler
   import vend_pkg::*;
#(
   parameter int INV_W      = 4,
   parameter int INV_INIT   = INV_INIT_DEF,
   parameter int GAP_CYCLES = 2,
   parameter int DB_CYCLES  = 3
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             btn_ni,
   input  logic             btn_di,
   input  logic             btn_qu,
   input  logic             btn_soda,
   input  logic             btn_diet,
   input  logic             restock,
   input  logic             giveSoda,
   input  logic             giveDiet,
   input  logic             change,
   output logic             ni,
   output logic             di,
   output logic             qu,
   output logic             soda,
   output logic             diet,
   output logic             reject,
   output logic             soda_out,
   output logic             diet_out,
   output logic [INV_W-1:0] soda_cnt,
   output logic [INV_W-1:0] diet_cnt
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   logic [NUM_REQ-1:0] w_btn;
   logic [NUM_REQ-1:0] w_rise;
   logic [NUM_REQ-1:0] r_pend;
   logic [NUM_REQ-1:0] w_clr;
   logic [NUM_REQ-1:0] w_issue;
   sched_state_t       r_state, w_state_next;
   logic [GAP_W-1:0]   r_gap, w_gap_next;
   logic               w_reject;
   logic               w_found;
   logic [2:0]         w_pick;
   logic               w_sold_out;
   logic [INV_W-1:0]   r_soda_cnt, r_diet_cnt;
   logic               r_gs_prev, r_gd_prev;
   logic               w_gs_rise, w_gd_rise;

   assign w_btn[REQ_NI]   = btn_ni;
   assign w_btn[REQ_DI]   = btn_di;
   assign w_btn[REQ_QU]   = btn_qu;
   assign w_btn[REQ_SODA] = btn_soda;
   assign w_btn[REQ_DIET] = btn_diet;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cond
         vend_btn_cond #(.DB_CYCLES(DB_CYCLES)) u_cond (
            .CLK    (CLK),
            .rst    (rst),
            .i_btn  (w_btn[gi]),
            .o_rise (w_rise[gi])
         );
      end
   endgenerate

   // Pending bits: set by a new press, cleared when served; a press on an
   // already-pending source is absorbed
   always_ff @(posedge CLK) begin
      if (rst) r_pend <= '0;
      else     r_pend <= (r_pend & ~w_clr) | (w_rise & ~r_pend);
   end

   // Scheduler state and gap counter
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_next;
         r_gap   <= w_gap_next;
      end
   end

   // Next-state, arbitration and pulse generation
   always_comb begin
      w_state_next = r_state;
      w_gap_next   = r_gap;
      w_issue      = '0;
      w_clr        = '0;
      w_reject     = 1'b0;
      w_found      = 1'b0;
      w_pick       = REQ_NI;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && r_pend[PRIO_ORDER[k]]) begin
            w_found = 1'b1;
            w_pick  = PRIO_ORDER[k];
         end
      end
      w_sold_out = ((w_pick == REQ_SODA) && (r_soda_cnt == '0)) ||
                   ((w_pick == REQ_DIET) && (r_diet_cnt == '0));
      case (r_state)
         ST_IDLE: begin
            if (change) begin
               w_state_next = ST_HOLD;
            end else if (w_found) begin
               w_clr[w_pick] = 1'b1;
               if (w_sold_out) begin
                  // Sold-out selection is dropped without using a slot
                  w_reject = 1'b1;
               end else begin
                  w_issue[w_pick] = 1'b1;
                  w_state_next    = ST_GAP;
                  w_gap_next      = '0;
               end
            end
         end
         ST_GAP: begin
            if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
               w_gap_next   = '0;
               w_state_next = change ? ST_HOLD : ST_IDLE;
            end else begin
               w_gap_next = r_gap + 1'b1;
            end
         end
         ST_HOLD: begin
            if (!change && !giveSoda && !giveDiet) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign w_gs_rise = giveSoda & ~r_gs_prev;
   assign w_gd_rise = giveDiet & ~r_gd_prev;

   // Dispense feedback history for edge detection
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_gs_prev <= 1'b0;
         r_gd_prev <= 1'b0;
      end else begin
         r_gs_prev <= giveSoda;
         r_gd_prev <= giveDiet;
      end
   end

   // Inventory: restock wins over a same-cycle dispense; counts stop at zero
   always_ff @(posedge CLK) begin
      if (rst || restock) begin
         r_soda_cnt <= INV_W'(INV_INIT);
         r_diet_cnt <= INV_W'(INV_INIT);
      end else begin
         if (w_gs_rise && (r_soda_cnt != '0)) r_soda_cnt <= r_soda_cnt - 1'b1;
         if (w_gd_rise && (r_diet_cnt != '0)) r_diet_cnt <= r_diet_cnt - 1'b1;
      end
   end

   assign ni       = w_issue[REQ_NI];
   assign di       = w_issue[REQ_DI];
   assign qu       = w_issue[REQ_QU];
   assign soda     = w_issue[REQ_SODA];
   assign diet     = w_issue[REQ_DIET];
   assign reject   = w_reject;
   assign soda_cnt = r_soda_cnt;
   assign diet_cnt = r_diet_cnt;
   assign soda_out = (r_soda_cnt == '0);
   assign diet_out = (r_diet_cnt == '0);

endmodule

// File: tb/tb_vend_req_scheduler.sv
// Self-checking bench for vend_req_scheduler: a per-cycle vector table,
// hand-written inventory/reset/latency sequences, and randomized stimulus
// checked against a timestamp-based reference model. Honours DEBOUNCE_EN.
module tb_vend_req_scheduler;

   localparam int INV_W      = 4;
   localparam int INV_INIT   = 10;
   localparam int GAP_CYCLES = 2;
   localparam int DB_CYCLES  = 3;
`ifdef DEBOUNCE_EN
   localparam int DBL = DB_CYCLES;
`else
   localparam int DBL = 0;
`endif

   // Bench bit order: 0 ni, 1 di, 2 qu, 3 soda, 4 diet, 5 reject
   logic             CLK = 1'b0;
   logic             rst = 1'b1;
   logic [4:0]       btn = '0;
   logic             change = 1'b0, giveSoda = 1'b0, giveDiet = 1'b0, restock = 1'b0;
   logic             ni, di, qu, soda, diet, reject, soda_out, diet_out;
   logic [INV_W-1:0] soda_cnt, diet_cnt;
   logic [5:0]       obs;
   int               total = 0;
   int               bad = 0;

   // Reference model state
   bit               m_on = 1'b0;
   bit   [4:0]       m_pend, m_h1, m_h2;
   bit               m_hold, m_gs_prev, m_gd_prev;
   int               m_t, m_free_at, m_sc, m_dc;

   vend_req_scheduler #(
      .INV_W(INV_W), .INV_INIT(INV_INIT), .GAP_CYCLES(GAP_CYCLES), .DB_CYCLES(DB_CYCLES)
   ) dut (
      .CLK(CLK), .rst(rst),
      .btn_ni(btn[0]), .btn_di(btn[1]), .btn_qu(btn[2]), .btn_soda(btn[3]), .btn_diet(btn[4]),
      .restock(restock), .giveSoda(giveSoda), .giveDiet(giveDiet), .change(change),
      .ni(ni), .di(di), .qu(qu), .soda(soda), .diet(diet), .reject(reject),
      .soda_out(soda_out), .diet_out(diet_out), .soda_cnt(soda_cnt), .diet_cnt(diet_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = '0; m_h1 = '0; m_h2 = '0;
      m_hold = 1'b0; m_gs_prev = 1'b0; m_gd_prev = 1'b0;
      m_t = 0; m_free_at = 0; m_sc = INV_INIT; m_dc = INV_INIT;
   endtask

   // One cycle of the reference model: predict outputs, compare, then advance
   task automatic model_step();
      bit [5:0] e;
      bit [4:0] clr;
      bit [4:0] edg;
      int       prio [5];
      prio = '{2, 1, 0, 3, 4};
      e    = '0;
      clr  = '0;
      edg  = m_h1 & ~m_h2;
      if (m_hold) begin
         if (!change && !giveSoda && !giveDiet) m_hold = 1'b0;
      end else if (m_t < m_free_at) begin
         if ((m_t == m_free_at - 1) && change) m_hold = 1'b1;
      end else if (change) begin
         m_hold = 1'b1;
      end else begin
         for (int k = 0; k < 5; k++) begin
            int i;
            i = prio[k];
            if (m_pend[i]) begin
               clr[i] = 1'b1;
               if ((i == 3 && m_sc == 0) || (i == 4 && m_dc == 0)) begin
                  e[5] = 1'b1;
               end else begin
                  e[i] = 1'b1;
                  m_free_at = m_t + GAP_CYCLES + 1;
               end
               break;
            end
         end
      end
      check("model_pulses", obs, e);
      check("model_soda_cnt", soda_cnt, m_sc);
      check("model_diet_cnt", diet_cnt, m_dc);
      check("model_soda_out", soda_out, (m_sc == 0) ? 1 : 0);
      check("model_diet_out", diet_out, (m_dc == 0) ? 1 : 0);
      m_pend = (m_pend & ~clr) | (edg & ~m_pend);
      m_h2   = m_h1;
      m_h1   = btn;
      if (restock) begin
         m_sc = INV_INIT;
         m_dc = INV_INIT;
      end else begin
         if (giveSoda && !m_gs_prev && m_sc > 0) m_sc--;
         if (giveDiet && !m_gd_prev && m_dc > 0) m_dc--;
      end
      m_gs_prev = giveSoda;
      m_gd_prev = giveDiet;
      m_t++;
   endtask

   // Drive one cycle of inputs after the edge, then sample the outputs
   task automatic step(input logic [4:0] b, input logic ch, input logic gs,
                       input logic gd, input logic rs);
      @(posedge CLK);
      #1;
      btn = b; change = ch; giveSoda = gs; giveDiet = gd; restock = rs;
      #1;
      obs = {reject, diet, soda, qu, di, ni};
      check("onehot", ($countones(obs[4:0]) <= 1) ? 1 : 0, 1);
      if (m_on) model_step();
   endtask

   task automatic do_reset(input bit chk);
      @(posedge CLK);
      #1;
      rst = 1'b1; btn = '0; change = 1'b0; giveSoda = 1'b0; giveDiet = 1'b0; restock = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      rst = 1'b0;
      #1;
      if (chk) begin
         check("rst_pulses", {reject, diet, soda, qu, di, ni}, 0);
         check("rst_soda_cnt", soda_cnt, INV_INIT);
         check("rst_diet_cnt", diet_cnt, INV_INIT);
         check("rst_soda_out", soda_out, 0);
         check("rst_diet_out", diet_out, 0);
      end
      model_reset();
   endtask

   typedef struct {
      logic [4:0] btn;
      logic       ch;
      logic [5:0] exp;
   } vec_t;

   localparam int NV = 50 + DBL;
   vec_t vec [NV];

   initial begin
      int n_a, n_b, at;
      logic [4:0] nb;
      logic nch, ngs, ngd;

      // Vector table: held qu, simultaneous coins, and a di request under change
      for (int i = 0; i < NV; i++) begin
         vec[i].btn = '0; vec[i].ch = 1'b0; vec[i].exp = '0;
      end
      for (int i = 2;  i <= 21; i++) vec[i].btn[2] = 1'b1;
      for (int i = 25; i <= 28; i++) vec[i].btn[2:0] = 3'b111;
      for (int i = 37; i <= 40; i++) vec[i].btn[1] = 1'b1;
      for (int i = 38 + DBL; i <= 42 + DBL; i++) vec[i].ch = 1'b1;
      vec[4  + DBL].exp = 6'b000100;
      vec[27 + DBL].exp = 6'b000100;
      vec[30 + DBL].exp = 6'b000010;
      vec[33 + DBL].exp = 6'b000001;
      vec[44 + DBL].exp = 6'b000010;

`ifndef DEBOUNCE_EN
      m_on = 1'b1;
`endif
      do_reset(1'b1);
      for (int i = 0; i < NV; i++) begin
         step(vec[i].btn, vec[i].ch, 1'b0, 1'b0, 1'b0);
         check($sformatf("vec%0d", i), obs, vec[i].exp);
      end

      // Soda depletion, saturation, sold-out reject, diet still served
      do_reset(1'b0);
      for (int e = 0; e < 10; e++) begin
         step(5'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         step(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check($sformatf("soda_cnt_after_%0d", e + 1), soda_cnt, 9 - e);
      end
      check("soda_out_empty", soda_out, 1);
      check("diet_cnt_untouched", diet_cnt, INV_INIT);
      step(5'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("soda_cnt_saturate", soda_cnt, 0);
      n_a = 0; n_b = 0;
      for (int k = 0; k < 8 + DBL; k++) begin
         step(5'b01000, 1'b0, 1'b0, 1'b0, 1'b0);
         n_a += obs[5]; n_b += obs[3];
      end
      check("soldout_reject_count", n_a, 1);
      check("soldout_soda_count", n_b, 0);
      n_a = 0; n_b = 0;
      for (int k = 0; k < 8 + DBL; k++) begin
         step(5'b10000, 1'b0, 1'b0, 1'b0, 1'b0);
         n_a += obs[4]; n_b += obs[5];
      end
      check("diet_after_soldout", n_a, 1);
      check("diet_no_reject", n_b, 0);

      // Restock overrides a same-cycle dispense edge
      do_reset(1'b0);
      for (int e = 0; e < 7; e++) begin
         step(5'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         step(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      check("diet_cnt_3", diet_cnt, 3);
      step(5'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      step(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("restock_diet_cnt", diet_cnt, INV_INIT);
      check("restock_diet_out", diet_out, 0);

      // Reset during HOLD drops the pending request
      do_reset(1'b0);
      n_a = 0;
      for (int k = 0; k < 4 + DBL; k++) begin
         step(5'b00100, 1'b1, 1'b0, 1'b0, 1'b0);
         n_a += obs[2];
      end
      check("hold_no_qu", n_a, 0);
      do_reset(1'b1);
      n_a = 0;
      for (int k = 0; k < 10 + DBL; k++) begin
         step(5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         n_a += $countones(obs);
      end
      check("after_reset_no_pulse", n_a, 0);

`ifdef DEBOUNCE_EN
      // A glitch shorter than the debounce window is ignored
      do_reset(1'b0);
      n_a = 0;
      for (int k = 0; k < 14; k++) begin
         step((k < 2) ? 5'b00001 : 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         n_a += obs[0];
      end
      check("glitch_no_ni", n_a, 0);
`endif

      // Press-to-pulse latency on a 5-cycle ni press
      do_reset(1'b0);
      n_a = 0; at = -1;
      for (int k = 0; k < 16; k++) begin
         step((k < 5) ? 5'b00001 : 5'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (obs[0]) begin
            n_a++;
            at = k;
         end
      end
      check("press_ni_count", n_a, 1);
      check("press_ni_latency", at, 2 + DBL);

`ifndef DEBOUNCE_EN
      // Randomized traffic against the reference model
      do_reset(1'b0);
      for (int c = 0; c < 1500; c++) begin
         nb = btn;
         for (int j = 0; j < 5; j++) if ($urandom_range(0, 5) == 0) nb[j] = ~nb[j];
         nch = ($urandom_range(0, 7) == 0) ? ~change : change;
         ngs = ($urandom_range(0, 3) == 0) ? ~giveSoda : giveSoda;
         ngd = ($urandom_range(0, 3) == 0) ? ~giveDiet : giveDiet;
         step(nb, nch, ngs, ngd, ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
